btn_event_ctrl: RTL and testbench

Button event controller for the signed-multiplier board top. It takes the debounced button levels and turns each press into one queued event. Events are presented one at a time to the top-level sequencing FSM over a valid/ready handshake, with fixed priority between buttons. Holding a button auto-repeats its event, which lets the operators step through operand values.

---
 rtl/btn_event_ctrl.sv | 171 +++++++++++++++++
 tb/tb_btn_event_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_ctrl.sv
// Button event controller: turns debounced button presses and auto-repeats into a
// single prioritized event stream presented over a valid/ready handshake.
module btn_event_ctrl #(
    parameter  int N_BTN       = 4,
    parameter  int TICK_DIV    = 50000,
    parameter  int REPEAT_DLY  = 500,
    parameter  int REPEAT_RATE = 100,
    localparam int IDW         = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_lvl,
    output logic             evt_valid,
    output logic [IDW-1:0]   evt_id,
    output logic             evt_repeat,
    input  logic             evt_ready,
    output logic             evt_drop
);

    localparam int PW   = $clog2(TICK_DIV);
    localparam int MAXH = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int HW   = $clog2(MAXH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_tgt;
    logic [HW-1:0]    r_hcnt;
    logic [PW-1:0]    r_pcnt;
    logic [N_BTN-1:0] r_prev;
    logic [N_BTN-1:0] r_pend;
    logic [N_BTN-1:0] r_rep;

    logic [N_BTN-1:0] w_press;
    logic             w_tick;
    logic             w_fire;
    logic [N_BTN-1:0] w_fire_vec;
    logic [N_BTN-1:0] w_set;
    logic             w_slot_free;
    logic             w_any_pend;
    logic [IDW-1:0]   w_sel;
    logic [N_BTN-1:0] w_clr;
    logic [N_BTN-1:0] w_load;
    logic             w_drop;

    function automatic logic [IDW-1:0] f_lowest(input logic [N_BTN-1:0] v);
        logic [IDW-1:0] idx;
        idx = {IDW{1'b0}};
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDW'(i);
            end
        end
        return idx;
    endfunction

    // Edge detect, repeat fire decode and pending-queue bookkeeping
    always_comb begin
        w_press     = btn_lvl & ~r_prev;
        w_tick      = (r_pcnt == PW'(TICK_DIV - 1));
        w_fire      = 1'b0;
        if ((w_press == {N_BTN{1'b0}}) && btn_lvl[r_tgt] && w_tick) begin
            case (r_state)
                S_DELAY:  w_fire = (r_hcnt == HW'(REPEAT_DLY - 1));
                S_REPEAT: w_fire = (r_hcnt == HW'(REPEAT_RATE - 1));
                default:  w_fire = 1'b0;
            endcase
        end else begin
            w_fire = 1'b0;
        end
        w_fire_vec        = {N_BTN{1'b0}};
        w_fire_vec[r_tgt] = w_fire;
        w_set             = w_press | w_fire_vec;
        w_slot_free       = ~evt_valid | evt_ready;
        w_any_pend        = |r_pend;
        w_sel             = f_lowest(r_pend);
        w_clr             = {N_BTN{1'b0}};
        w_clr[w_sel]      = w_slot_free & w_any_pend;
        // A set on a bit being cleared this cycle re-arms it rather than dropping
        w_load            = w_set & (~r_pend | w_clr);
        w_drop            = |(w_set & r_pend & ~w_clr);
    end

    // Pending queue, previous-level history and output slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev     <= {N_BTN{1'b1}};
            r_pend     <= {N_BTN{1'b0}};
            r_rep      <= {N_BTN{1'b0}};
            evt_valid  <= 1'b0;
            evt_id     <= {IDW{1'b0}};
            evt_repeat <= 1'b0;
            evt_drop   <= 1'b0;
        end else begin
            r_prev   <= btn_lvl;
            r_pend   <= (r_pend & ~w_clr) | w_set;
            r_rep    <= (r_rep & ~w_load) | (w_load & w_fire_vec & ~w_press);
            evt_drop <= w_drop;
            if (w_slot_free) begin
                if (w_any_pend) begin
                    evt_valid  <= 1'b1;
                    evt_id     <= w_sel;
                    evt_repeat <= r_rep[w_sel];
                end else begin
                    evt_valid  <= 1'b0;
                end
            end
        end
    end

    // Free-running repeat-timing prescaler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= {PW{1'b0}};
        end else if (w_tick) begin
            r_pcnt <= {PW{1'b0}};
        end else begin
            r_pcnt <= r_pcnt + PW'(1);
        end
    end

    // Auto-repeat FSM; any new press retargets it to the lowest pressed button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tgt   <= {IDW{1'b0}};
            r_hcnt  <= {HW{1'b0}};
        end else if (w_press != {N_BTN{1'b0}}) begin
            r_state <= S_DELAY;
            r_tgt   <= f_lowest(w_press);
            r_hcnt  <= {HW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_DELAY: begin
                    if (!btn_lvl[r_tgt]) begin
                        r_state <= S_IDLE;
                    end else if (w_tick) begin
                        if (r_hcnt == HW'(REPEAT_DLY - 1)) begin
                            r_hcnt  <= {HW{1'b0}};
                            r_state <= S_REPEAT;
                        end else begin
                            r_hcnt <= r_hcnt + HW'(1);
                        end
                    end
                end
                S_REPEAT: begin
                    if (!btn_lvl[r_tgt]) begin
                        r_state <= S_IDLE;
                    end else if (w_tick) begin
                        if (r_hcnt == HW'(REPEAT_RATE - 1)) begin
                            r_hcnt <= {HW{1'b0}};
                        end else begin
                            r_hcnt <= r_hcnt + HW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed self-checking bench for btn_event_ctrl with short repeat timing.
module tb_btn_event_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] btn_lvl;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_repeat;
    logic       evt_ready;
    logic       evt_drop;

    int n_assert = 0;
    int n_fail   = 0;

    btn_event_ctrl #(
        .N_BTN      (4),
        .TICK_DIV   (4),
        .REPEAT_DLY (3),
        .REPEAT_RATE(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_lvl   (btn_lvl),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_repeat(evt_repeat),
        .evt_ready (evt_ready),
        .evt_drop  (evt_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        int n_press;
        int n_rep;
        int n_drop;
        int first_press_k;
        int first_rep_k;
        int last_rep_k;
        int found;

        // Reset with btn 1 already held
        rst       = 1'b1;
        btn_lvl   = 4'b0010;
        evt_ready = 1'b0;
        step();
        step();
        step();
        chk("rst_valid", {31'd0, evt_valid}, 32'd0);
        chk("rst_id", {30'd0, evt_id}, 32'd0);
        chk("rst_repeat", {31'd0, evt_repeat}, 32'd0);
        chk("rst_drop", {31'd0, evt_drop}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held_no_evt", {31'd0, evt_valid}, 32'd0);
        end

        btn_lvl = 4'b1010;
        step();
        chk("b3_e0_valid", {31'd0, evt_valid}, 32'd0);
        step();
        chk("b3_e1_valid", {31'd0, evt_valid}, 32'd1);
        chk("b3_e1_id", {30'd0, evt_id}, 32'd3);
        chk("b3_e1_rep", {31'd0, evt_repeat}, 32'd0);
        btn_lvl   = 4'b0000;
        evt_ready = 1'b1;
        step();
        chk("b3_consumed", {31'd0, evt_valid}, 32'd0);

        // Priority: btn 2 and btn 0 together
        btn_lvl = 4'b0101;
        step();
        chk("pri_e0_valid", {31'd0, evt_valid}, 32'd0);
        step();
        chk("pri_first_valid", {31'd0, evt_valid}, 32'd1);
        chk("pri_first_id", {30'd0, evt_id}, 32'd0);
        chk("pri_first_drop", {31'd0, evt_drop}, 32'd0);
        step();
        chk("pri_second_valid", {31'd0, evt_valid}, 32'd1);
        chk("pri_second_id", {30'd0, evt_id}, 32'd2);
        chk("pri_second_drop", {31'd0, evt_drop}, 32'd0);
        step();
        chk("pri_empty", {31'd0, evt_valid}, 32'd0);
        btn_lvl = 4'b0000;
        step();

        // Backpressure: three presses of btn 1 with ready low
        evt_ready = 1'b0;
        btn_lvl = 4'b0010;
        step();
        btn_lvl = 4'b0000;
        step();
        chk("bp_slot_valid", {31'd0, evt_valid}, 32'd1);
        chk("bp_slot_id", {30'd0, evt_id}, 32'd1);
        btn_lvl = 4'b0010;
        step();
        chk("bp_press2_drop", {31'd0, evt_drop}, 32'd0);
        btn_lvl = 4'b0000;
        step();
        chk("bp_idle_drop", {31'd0, evt_drop}, 32'd0);
        btn_lvl = 4'b0010;
        step();
        chk("bp_press3_drop", {31'd0, evt_drop}, 32'd1);
        chk("bp_hold_id", {30'd0, evt_id}, 32'd1);
        btn_lvl = 4'b0000;
        step();
        chk("bp_drop_pulse_end", {31'd0, evt_drop}, 32'd0);
        chk("bp_still_valid", {31'd0, evt_valid}, 32'd1);
        evt_ready = 1'b1;
        step();
        chk("bp_second_valid", {31'd0, evt_valid}, 32'd1);
        chk("bp_second_id", {30'd0, evt_id}, 32'd1);
        chk("bp_second_rep", {31'd0, evt_repeat}, 32'd0);
        step();
        chk("bp_drained", {31'd0, evt_valid}, 32'd0);

        // Auto-repeat on btn 2, released before the 41st edge
        n_press = 0;
        n_rep = 0;
        n_drop = 0;
        first_press_k = 0;
        first_rep_k = 0;
        last_rep_k = 0;
        btn_lvl = 4'b0100;
        for (int k = 1; k <= 41; k++) begin
            if (k == 41) btn_lvl = 4'b0000;
            step();
            if (evt_drop) n_drop++;
            if (evt_valid) begin
                chk("ar_id", {30'd0, evt_id}, 32'd2);
                if (evt_repeat) begin
                    if (n_rep == 0) first_rep_k = k;
                    else chk("ar_spacing", k - last_rep_k, 32'd8);
                    last_rep_k = k;
                    n_rep++;
                end else begin
                    if (n_press == 0) first_press_k = k;
                    n_press++;
                end
            end
        end
        chk("ar_press_count", n_press, 32'd1);
        chk("ar_press_k", first_press_k, 32'd2);
        chk("ar_rep_count", n_rep, 32'd4);
        chk("ar_first_rep_window",
            {31'd0, ((first_rep_k - first_press_k) >= 8) && ((first_rep_k - first_press_k) <= 12)},
            32'd1);
        chk("ar_drops", n_drop, 32'd0);
        n_rep = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (evt_valid) n_rep++;
        end
        chk("ar_no_evt_after_release", n_rep, 32'd0);

        // Retarget: btn 0 reaches REPEAT, then btn 1 is pressed
        found = 0;
        btn_lvl = 4'b0001;
        for (int k = 0; k < 30 && found == 0; k++) begin
            step();
            if (evt_valid && evt_repeat && (evt_id == 2'd0)) found = 1;
        end
        chk("rt_b0_repeat_seen", found, 32'd1);
        btn_lvl = 4'b0011;
        step();
        chk("rt_e0_valid", {31'd0, evt_valid}, 32'd0);
        step();
        chk("rt_press_valid", {31'd0, evt_valid}, 32'd1);
        chk("rt_press_id", {30'd0, evt_id}, 32'd1);
        chk("rt_press_rep", {31'd0, evt_repeat}, 32'd0);
        n_rep = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (evt_valid) begin
                chk("rt_rep_id", {30'd0, evt_id}, 32'd1);
                chk("rt_rep_flag", {31'd0, evt_repeat}, 32'd1);
                n_rep++;
            end
        end
        chk("rt_rep_count", n_rep, 32'd3);
        btn_lvl = 4'b0001;
        n_rep = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (evt_valid) n_rep++;
        end
        chk("rt_idle_after_release", n_rep, 32'd0);

        // Asynchronous reset with one event in the slot and two pending
        evt_ready = 1'b0;
        btn_lvl = 4'b0000;
        step();
        btn_lvl = 4'b0111;
        step();
        step();
        chk("mr_slot_valid", {31'd0, evt_valid}, 32'd1);
        chk("mr_slot_id", {30'd0, evt_id}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_valid_cleared", {31'd0, evt_valid}, 32'd0);
        chk("mr_id_cleared", {30'd0, evt_id}, 32'd0);
        chk("mr_rep_cleared", {31'd0, evt_repeat}, 32'd0);
        chk("mr_drop_cleared", {31'd0, evt_drop}, 32'd0);
        #1;
        rst = 1'b0;
        evt_ready = 1'b1;
        n_rep = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (evt_valid) n_rep++;
        end
        chk("mr_no_stale_evt", n_rep, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
